// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer sequencing controller.
package countdown_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
  localparam logic [STATE_W-1:0] ST_PAUSE = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    PAUSE = ST_PAUSE,
    DONE  = ST_DONE
  } state_e;

  // Command priority when several arrive in one cycle (highest first):
  //   rst > set > pause > start
  // The terminal-count event is not a command; a load in the same cycle
  // suppresses its tick.

endpackage

// File: rtl/countdown_tick_prescaler.sv
// Decrement-tick prescaler: counts 0..TICK_DIV-1 while enabled, wraps at the
// terminal count and flags it combinationally. clr wins over en.
module tick_prescaler
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic term
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign term = en && (cnt_q == LAST);

  // next count: clear, wrap at terminal, or advance while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (term) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + 1'b1;
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Sequencing controller for the cascaded ms/s/min down-counter chain.
// Turns start/pause/set pulses into stage load and decrement strobes, stops
// the chain at all-zero and raises an expiry alarm.
// Optional feature macro: COUNTDOWN_ALARM_BLINK_EN (blinking alarm in DONE).
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int TICK_DIV   = 100000,
  parameter int ALARM_HALF = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       pause_i,
  input  logic       set_i,
  input  logic       zero_i,
  output logic       load_o,
  output logic       tick_o,
  output logic       done_o,
  output logic       alarm_o,
  output logic       running_o,
  output logic [1:0] state_o
);

  // Elaboration-time sanity checks on the configuration.
  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("countdown_ctrl: TICK_DIV must be >= 2");
  end
  if (ALARM_HALF < 1) begin : g_bad_alarm_half
    $error("countdown_ctrl: ALARM_HALF must be >= 1");
  end

  state_e state_q, state_d;
  logic   load_q, load_d;
  logic   tick_q, tick_d;
  logic   done_q, done_d;
  logic   alarm_q, alarm_d;
  logic   running_q, running_d;
  logic   pre_clr, pre_term;

  // Prescaler runs only in RUN, so a pause freezes the sub-tick phase.
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == RUN),
    .clr  (pre_clr),
    .term (pre_term)
  );

  // next state and strobes: commands by priority, then the terminal count
  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    pre_clr = 1'b0;

    if (set_i) begin
      load_d  = 1'b1;
      pre_clr = 1'b1;
      state_d = PAUSE;
    end else if (pause_i) begin
      case (state_q)
        RUN:     state_d = PAUSE;
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end else if (start_i) begin
      case (state_q)
        IDLE, DONE: begin
          load_d  = 1'b1;
          pre_clr = 1'b1;
          state_d = RUN;
        end
        PAUSE:   state_d = RUN;
        default: state_d = state_q;
      endcase
    end

    // At all-zero the chain must not be decremented again; expire instead.
    if (pre_term && !load_d) begin
      if (!zero_i) begin
        tick_d = 1'b1;
      end else if (state_d == RUN) begin
        done_d  = 1'b1;
        state_d = DONE;
      end
    end
  end

  assign running_d = (state_d == RUN);

`ifdef COUNTDOWN_ALARM_BLINK_EN
  localparam int BW = $clog2(ALARM_HALF + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(ALARM_HALF - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;

  // blinking alarm: starts high on DONE entry, toggles every ALARM_HALF cycles
  always_comb begin
    blink_cnt_d = '0;
    alarm_d     = 1'b0;
    if (state_d == DONE) begin
      if (state_q != DONE) begin
        alarm_d = 1'b1;
      end else if (blink_cnt_q == BLINK_LAST) begin
        alarm_d = ~alarm_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        alarm_d     = alarm_q;
      end
    end
  end

  // blink counter register
  always_ff @(posedge clk) begin
    if (rst) blink_cnt_q <= '0;
    else     blink_cnt_q <= blink_cnt_d;
  end
`else
  // steady alarm while expired
  always_comb begin
    alarm_d = (state_d == DONE);
  end
`endif

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      load_q    <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      load_q    <= load_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      alarm_q   <= alarm_d;
      running_q <= running_d;
    end
  end

  assign load_o    = load_q;
  assign tick_o    = tick_q;
  assign done_o    = done_q;
  assign alarm_o   = alarm_q;
  assign running_o = running_q;
  assign state_o   = state_q;

endmodule
